// File: rtl/uart_echo_tester_pkg.sv
// Shared types and default timing constants for the UART echo tester.
package uart_echo_tester_pkg;

  localparam int unsigned DefaultClkHz         = 48_000_000;
  localparam int unsigned DefaultBaud          = 115_200;
  localparam int unsigned DefaultTimeoutCycles = 48_000;   // 1 ms at 48 MHz
  localparam int unsigned DefaultGapCycles     = 480_000;  // 10 ms at 48 MHz
  localparam int unsigned DefaultCntW          = 16;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StLoad       = 3'd1,
    StStartTx    = 3'd2,
    StWaitTxdone = 3'd3,
    StWaitEcho   = 3'd4,
    StGap        = 3'd5
  } state_e;

endpackage

// File: rtl/uart_echo_tester_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module uart_echo_tester_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_echo_tester.sv
// Sends an incrementing byte pattern through uart_tx, checks each echo from uart_rx,
// and keeps ok/error/timeout statistics.
module uart_echo_tester
  import uart_echo_tester_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned GAP_CYCLES     = DefaultGapCycles,
  parameter logic [7:0]  START_BYTE     = 8'h00,
  parameter int unsigned CNT_W          = DefaultCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [7:0]       data_to_tx,
  output logic             start_tx,
  input  logic             tx_busy,
  input  logic [7:0]       data_received,
  input  logic             rx_done,
  input  logic             parity_error,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [7:0]       last_rx,
  output logic             link_ok,
  output logic             busy
);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [7:0]  data_to_tx_q, data_to_tx_d;
  logic [7:0]  last_rx_q, last_rx_d;
  logic        link_ok_q, link_ok_d;
  logic        echo_seen_q, echo_seen_d;
  logic        inc_tx, inc_ok, inc_err, inc_to;
  logic        rx_take, rx_late, rx_match, timer_to, timer_gap;

  assign timer_to  = (timer_q == TIMEOUT_CYCLES - 1);
  assign timer_gap = (timer_q == GAP_CYCLES - 1);
  assign rx_match  = !parity_error && (data_received == data_to_tx_q);
  assign rx_take   = rx_done && (state_q inside {StStartTx, StWaitTxdone, StWaitEcho, StGap});
  // Anything after the first echo of an exchange, or during the gap, is a late echo.
  assign rx_late   = (state_q == StGap) || echo_seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      pattern_q    <= START_BYTE;
      data_to_tx_q <= START_BYTE;
      last_rx_q    <= 8'h00;
      link_ok_q    <= 1'b0;
      echo_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pattern_q    <= pattern_d;
      data_to_tx_q <= data_to_tx_d;
      last_rx_q    <= last_rx_d;
      link_ok_q    <= link_ok_d;
      echo_seen_q  <= echo_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 32'd1;
    pattern_d    = pattern_q;
    data_to_tx_d = data_to_tx_q;
    last_rx_d    = last_rx_q;
    link_ok_d    = link_ok_q;
    echo_seen_d  = echo_seen_q;
    inc_tx       = 1'b0;
    inc_ok       = 1'b0;
    inc_err      = 1'b0;
    inc_to       = 1'b0;

    // Echo evaluation first so a same-cycle timeout below can force link_ok low.
    if (rx_take) begin
      last_rx_d   = data_received;
      echo_seen_d = 1'b1;
      if (rx_match && !rx_late) begin
        inc_ok    = 1'b1;
        link_ok_d = 1'b1;
      end else begin
        inc_err   = 1'b1;
        link_ok_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (enable) state_d = StLoad;
      end
      StLoad: begin
        data_to_tx_d = pattern_q;
        inc_tx       = 1'b1;
        echo_seen_d  = 1'b0;
        timer_d      = '0;
        state_d      = StStartTx;
      end
      StStartTx: begin
        if (tx_busy) begin
          timer_d = '0;
          state_d = StWaitTxdone;
        end else if (timer_to) begin
          inc_to    = 1'b1;
          link_ok_d = 1'b0;
          timer_d   = '0;
          state_d   = StGap;
        end
      end
      StWaitTxdone: begin
        if (!tx_busy) begin
          timer_d = '0;
          state_d = (echo_seen_q || rx_done) ? StGap : StWaitEcho;
        end
      end
      StWaitEcho: begin
        if (rx_done) begin
          timer_d = '0;
          state_d = StGap;
        end else if (timer_to) begin
          inc_to    = 1'b1;
          link_ok_d = 1'b0;
          timer_d   = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (timer_gap) begin
          pattern_d = pattern_q + 8'd1;
          timer_d   = '0;
          state_d   = enable ? StLoad : StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Decoded from state so reset drops start_tx asynchronously.
  always_comb begin
    start_tx = (state_q == StStartTx);
    busy     = (state_q != StIdle);
  end

  assign data_to_tx = data_to_tx_q;
  assign last_rx    = last_rx_q;
  assign link_ok    = link_ok_q;

  uart_echo_tester_sat_counter #(.W(CNT_W)) u_tx_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_tx),
    .count (tx_count)
  );

  uart_echo_tester_sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_ok),
    .count (ok_count)
  );

  uart_echo_tester_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_err),
    .count (err_count)
  );

  uart_echo_tester_sat_counter #(.W(CNT_W)) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_to),
    .count (timeout_count)
  );

endmodule

// File: tb/tb_uart_echo_tester.sv
// Scoreboard bench: a far-end model answers the DUT, expectations are queued per exchange
// and a monitor pops them whenever a byte is launched or a statistics counter moves.
module tb_uart_echo_tester;

  localparam int unsigned TO = 40;
  localparam int unsigned GP = 20;

  localparam logic [1:0] KOk = 2'd0;
  localparam logic [1:0] KErr = 2'd1;
  localparam logic [1:0] KTo = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] rx;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  data_to_tx, data_received, last_rx;
  logic        start_tx, tx_busy, rx_done, parity_error, link_ok, busy;
  logic [15:0] tx_count, ok_count, err_count, timeout_count;

  logic        enable2, tx_busy2, rx_done2, start_tx2, link_ok2, busy2;
  logic [7:0]  data_to_tx2, data_received2, last_rx2;
  logic [15:0] tx_count2, ok_count2, err_count2, timeout_count2;

  int   n_pass = 0;
  int   n_checks = 0;
  int   cyc = 0;
  int   drop_cyc = 0;
  int   mode = 0;  // 0 ideal, 1 xor 0x01, 2 silent, 3 never busy, 4 parity + late echo
  logic [7:0] tx_q[$];
  logic [7:0] tx2_q[$];
  res_t       res_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_tester #(
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GP),
    .START_BYTE     (8'h00),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .data_to_tx    (data_to_tx),
    .start_tx      (start_tx),
    .tx_busy       (tx_busy),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .tx_count      (tx_count),
    .ok_count      (ok_count),
    .err_count     (err_count),
    .timeout_count (timeout_count),
    .last_rx       (last_rx),
    .link_ok       (link_ok),
    .busy          (busy)
  );

  uart_echo_tester #(
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GP),
    .START_BYTE     (8'hFE),
    .CNT_W          (16)
  ) dut_fe (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable2),
    .data_to_tx    (data_to_tx2),
    .start_tx      (start_tx2),
    .tx_busy       (tx_busy2),
    .data_received (data_received2),
    .rx_done       (rx_done2),
    .parity_error  (1'b0),
    .tx_count      (tx_count2),
    .ok_count      (ok_count2),
    .err_count     (err_count2),
    .timeout_count (timeout_count2),
    .last_rx       (last_rx2),
    .link_ok       (link_ok2),
    .busy          (busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Far end of the main DUT: uart_tx busy window, then an echo shaped by mode.
  initial begin : far_end
    logic [7:0] sent_b;
    tx_busy = 1'b0; rx_done = 1'b0; parity_error = 1'b0; data_received = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (start_tx && mode != 3) begin
        sent_b  = data_to_tx;
        tx_busy = 1'b1;
        repeat (8) @(posedge clk);
        #1 tx_busy = 1'b0;
        drop_cyc = cyc;
        if (mode != 2) begin
          repeat (5) @(posedge clk);
          #1;
          data_received = (mode == 1) ? (sent_b ^ 8'h01) : sent_b;
          parity_error  = (mode == 4);
          rx_done       = 1'b1;
          @(posedge clk); #1;
          rx_done = 1'b0; parity_error = 1'b0;
          if (mode == 4) begin
            repeat (3) @(posedge clk);
            #1 data_received = 8'h55; rx_done = 1'b1;
            @(posedge clk); #1 rx_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin : far_end_fe
    logic [7:0] sent_b;
    tx_busy2 = 1'b0; rx_done2 = 1'b0; data_received2 = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (start_tx2) begin
        sent_b   = data_to_tx2;
        tx_busy2 = 1'b1;
        repeat (8) @(posedge clk);
        #1 tx_busy2 = 1'b0;
        repeat (5) @(posedge clk);
        #1 data_received2 = sent_b; rx_done2 = 1'b1;
        @(posedge clk); #1 rx_done2 = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic        prev_start, prev_start2;
    logic [15:0] p_ok, p_err, p_to;
    logic [1:0]  kind;
    res_t        r;
    prev_start = 1'b0; prev_start2 = 1'b0; p_ok = '0; p_err = '0; p_to = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_start = 1'b0; prev_start2 = 1'b0; p_ok = '0; p_err = '0; p_to = '0;
      end else begin
        if (start_tx && !prev_start) begin
          if (tx_q.size() == 0) check("unexpected tx byte", 32'(data_to_tx), 32'hFFFF_FFFF);
          else check("tx byte", 32'(data_to_tx), 32'(tx_q.pop_front()));
        end
        if (start_tx2 && !prev_start2) begin
          if (tx2_q.size() == 0) check("unexpected fe tx", 32'(data_to_tx2), 32'hFFFF_FFFF);
          else check("fe tx byte", 32'(data_to_tx2), 32'(tx2_q.pop_front()));
        end
        prev_start  = start_tx;
        prev_start2 = start_tx2;
        if (ok_count != p_ok || err_count != p_err || timeout_count != p_to) begin
          kind = (ok_count != p_ok) ? KOk : (err_count != p_err) ? KErr : KTo;
          if (res_q.size() == 0) begin
            check("unexpected result", 32'(kind), 32'hFFFF_FFFF);
          end else begin
            r = res_q.pop_front();
            check("result kind", 32'(kind), 32'(r.kind));
            check("link_ok", 32'(link_ok), (r.kind == KOk) ? 32'd1 : 32'd0);
            if (r.kind != KTo) check("last_rx", 32'(last_rx), 32'(r.rx));
            else check("timeout latency", cyc - drop_cyc, TO + 1);
          end
          p_ok = ok_count; p_err = err_count; p_to = timeout_count;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic [1:0] k, input logic [7:0] rx);
    res_t r;
    r.kind = k; r.rx = rx;
    tx_q.push_back(b);
    res_q.push_back(r);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) begin @(posedge clk); #1; end
    check("returned idle", 32'(busy), 32'd0);
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    for (int i = 0; i < 5000 && tx_count != 16'(n); i++) begin @(posedge clk); #1; end
    check("tx_count reached", 32'(tx_count), 32'(n));
    enable = 1'b0;
    wait_idle();
    check("scoreboard drained", 32'(tx_q.size() + res_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : stim
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst start_tx", 32'(start_tx), 32'd0);
    check("rst data_to_tx", 32'(data_to_tx), 32'h00);
    check("rst busy", 32'(busy), 32'd0);
    check("rst link_ok", 32'(link_ok), 32'd0);
    check("rst last_rx", 32'(last_rx), 32'd0);
    check("rst counters", 32'(tx_count | ok_count | err_count | timeout_count), 32'd0);
    check("rst fe data_to_tx", 32'(data_to_tx2), 32'hFE);
    reset = 1'b0;

    mode = 0;
    for (int i = 0; i < 3; i++) push(8'(i), KOk, 8'(i));
    run(3);
    check("ideal ok_count", 32'(ok_count), 32'd3);
    check("ideal err_count", 32'(err_count), 32'd0);
    check("ideal link_ok", 32'(link_ok), 32'd1);

    do_reset();
    mode = 1;
    push(8'h00, KErr, 8'h01);
    push(8'h01, KErr, 8'h00);
    run(2);
    check("xor err_count", 32'(err_count), 32'd2);
    check("xor ok_count", 32'(ok_count), 32'd0);
    check("xor link_ok", 32'(link_ok), 32'd0);

    do_reset();
    mode = 2;
    push(8'h00, KTo, 8'h00);
    push(8'h01, KTo, 8'h00);
    run(2);
    check("silent timeout_count", 32'(timeout_count), 32'd2);
    check("silent err_count", 32'(err_count), 32'd0);

    do_reset();
    mode = 4;
    push(8'h00, KErr, 8'h00);
    res_q.push_back('{kind: KErr, rx: 8'h55});
    run(1);
    check("parity err_count", 32'(err_count), 32'd2);
    check("parity ok_count", 32'(ok_count), 32'd0);

    mode = 0;
    tx2_q.push_back(8'hFE); tx2_q.push_back(8'hFF); tx2_q.push_back(8'h00);
    enable2 = 1'b1;
    for (int i = 0; i < 5000 && tx_count2 != 16'd3; i++) begin @(posedge clk); #1; end
    enable2 = 1'b0;
    for (int i = 0; i < 5000 && busy2; i++) begin @(posedge clk); #1; end
    check("fe tx_count", 32'(tx_count2), 32'd3);
    check("fe ok_count", 32'(ok_count2), 32'd3);
    check("fe err+timeout", 32'(err_count2 + timeout_count2), 32'd0);
    check("fe link_ok", 32'(link_ok2), 32'd1);
    check("fe bytes drained", 32'(tx2_q.size()), 32'd0);

    do_reset();
    mode = 3;
    tx_q.push_back(8'h00);
    enable = 1'b1;
    for (int i = 0; i < 200 && !start_tx; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    check("start_tx held", 32'(start_tx), 32'd1);
    reset = 1'b1;
    #1;
    check("async start_tx drop", 32'(start_tx), 32'd0);
    check("async tx_count clear", 32'(tx_count), 32'd0);
    check("async busy clear", 32'(busy), 32'd0);
    @(posedge clk); #1;
    mode = 0;
    push(8'h00, KOk, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5000 && tx_count != 16'd1; i++) begin @(posedge clk); #1; end
    enable = 1'b0;
    wait_idle();
    check("post-reset ok_count", 32'(ok_count), 32'd1);
    check("post-reset drained", 32'(tx_q.size() + res_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
